// File: rtl/pll_lock_seq_pkg.sv
// Shared state encoding and default parameters for the PLL lock sequencer.
package pll_lock_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_PLL_RST_CYCLES     = 16;
    localparam int DEF_LOCK_STABLE_CYCLES = 1250;
    localparam int DEF_RELEASE_DELAY      = 125;
    localparam int DEF_LOCK_TIMEOUT       = 125000;
    localparam int DEF_CNT_W              = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level, synchronous reset to 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-qualification sequencer with system reset release and event counters.
// Define PLL_AUTO_RESET_EN to re-pulse the PLL on lock timeout and on lock loss in RUN.
module pll_lock_sequencer
    import pll_lock_seq_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RELEASE_DELAY      = DEF_RELEASE_DELAY,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int CNT_W              = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             cnt_clr,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic [2:0]       state_dbg
);

    localparam int MAX_CYC = max_int(max_int(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                     max_int(RELEASE_DELAY, LOCK_TIMEOUT));
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] LAST_RST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LAST_STABLE  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] LAST_RELEASE = CW'(RELEASE_DELAY - 1);
    localparam logic [CW-1:0] LAST_WAIT    = CW'(LOCK_TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic          locked_s;
    state_t        state;
    state_t        nxt_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt_cnt;
    logic          loss_ev;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (locked_s)
    );

`ifdef PLL_AUTO_RESET_EN
    logic             timeout_ev;
    logic [CNT_W-1:0] timeout_cnt;
`endif

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        loss_ev   = 1'b0;
`ifdef PLL_AUTO_RESET_EN
        timeout_ev = 1'b0;
`endif
        case (state)
            PLL_RST: begin
                if (cnt == LAST_RST) begin
                    nxt_state = WAIT_LOCK;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    nxt_state = STABLE;
                    nxt_cnt   = '0;
                end else if (cnt == LAST_WAIT) begin
`ifdef PLL_AUTO_RESET_EN
                    nxt_state  = PLL_RST;
                    nxt_cnt    = '0;
                    timeout_ev = 1'b1;
`else
                    // Without auto-reset the wait is unbounded; park the counter.
                    nxt_cnt = cnt;
`endif
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    nxt_state = WAIT_LOCK;
                    nxt_cnt   = '0;
                end else if (cnt == LAST_STABLE) begin
                    nxt_state = RELEASE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    nxt_state = WAIT_LOCK;
                    nxt_cnt   = '0;
                end else if (cnt == LAST_RELEASE) begin
                    nxt_state = RUN;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    loss_ev = 1'b1;
                    nxt_cnt = '0;
`ifdef PLL_AUTO_RESET_EN
                    nxt_state = PLL_RST;
`else
                    nxt_state = WAIT_LOCK;
`endif
                end
            end
            default: begin
                nxt_state = PLL_RST;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state           <= PLL_RST;
            cnt             <= '0;
            pll_rst         <= 1'b1;
            sys_rst         <= 1'b1;
            ready           <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            pll_rst <= (nxt_state == PLL_RST);
            sys_rst <= (nxt_state != RUN);
            ready   <= (nxt_state == RUN);
            if (cnt_clr) begin
                lock_loss_count <= '0;
            end else if (loss_ev) begin
                lock_loss_count <= sat_inc(lock_loss_count);
            end
        end
    end

`ifdef PLL_AUTO_RESET_EN
    always_ff @(posedge refclk) begin
        if (rst || cnt_clr) begin
            timeout_cnt <= '0;
        end else if (timeout_ev) begin
            timeout_cnt <= sat_inc(timeout_cnt);
        end
    end

    assign timeout_count = timeout_cnt;
`else
    assign timeout_count = '0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_pll_lock_sequencer;

    localparam int S_PRST  = 0;
    localparam int S_SRST  = 1;
    localparam int S_RDY   = 2;
    localparam int S_LOSS  = 3;
    localparam int S_TMO   = 4;
    localparam int S_STATE = 5;

`ifdef PLL_AUTO_RESET_EN
    localparam int RELOCK     = 19;
    localparam int LOSS_STATE = 0;
`else
    localparam int RELOCK     = 16;
    localparam int LOSS_STATE = 1;
`endif

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       cnt_clr;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] lock_loss_count;
    logic [7:0] timeout_count;
    logic [2:0] state_dbg;

    int   tcyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    pll_lock_sequencer #(
        .SYNC_STAGES       (2),
        .PLL_RST_CYCLES    (3),
        .LOCK_STABLE_CYCLES(8),
        .RELEASE_DELAY     (4),
        .LOCK_TIMEOUT      (50),
        .CNT_W             (8)
    ) dut (
        .refclk         (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .cnt_clr        (cnt_clr),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .lock_loss_count(lock_loss_count),
        .timeout_count  (timeout_count),
        .state_dbg      (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) tcyc <= tcyc + 1;

    function automatic int dut_val(input int s);
        case (s)
            S_PRST:  return int'(pll_rst);
            S_SRST:  return int'(sys_rst);
            S_RDY:   return int'(ready);
            S_LOSS:  return int'(lock_loss_count);
            S_TMO:   return int'(timeout_count);
            default: return int'(state_dbg);
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_PRST:  return "pll_rst";
            S_SRST:  return "sys_rst";
            S_RDY:   return "ready";
            S_LOSS:  return "lock_loss_count";
            S_TMO:   return "timeout_count";
            default: return "state_dbg";
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == tcyc) begin
                n_vec++;
                if (dut_val(sb[i].sig) != sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s at cycle %0d: got %0d expected %0d",
                             sig_name(sb[i].sig), tcyc, dut_val(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < tcyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s stale expectation for cycle %0d: got unchecked expected %0d",
                         sig_name(sb[i].sig), sb[i].cyc, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (tcyc < c) tick();
    endtask

    task automatic want(input int c, input int s, input int v);
        sb.push_back('{cyc: c, sig: s, val: v});
    endtask

    // Returns the cycle index of the first cycle after the last reset edge.
    task automatic do_reset(output int b);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        b = tcyc;
    endtask

    initial begin
        int base;
        int k;
        int r;
        rst        = 1'b1;
        pll_locked = 1'b0;
        cnt_clr    = 1'b0;

        // Clean lock
        do_reset(base);
        want(base + 0,  S_PRST, 1);
        want(base + 2,  S_PRST, 1);
        want(base + 3,  S_PRST, 0);
        want(base + 3,  S_STATE, 1);
        want(base + 13, S_STATE, 2);
        want(base + 21, S_STATE, 3);
        want(base + 24, S_RDY, 0);
        want(base + 24, S_SRST, 1);
        want(base + 25, S_RDY, 1);
        want(base + 25, S_SRST, 0);
        want(base + 25, S_STATE, 4);
        want(base + 25, S_LOSS, 0);
        wait_until(base + 10);
        pll_locked = 1'b1;
        wait_until(base + 30);

        // Single-cycle glitch during STABLE, then loss in RUN
        pll_locked = 1'b0;
        do_reset(base);
        want(base + 17, S_STATE, 2);
        want(base + 18, S_STATE, 2);
        want(base + 19, S_STATE, 1);
        want(base + 20, S_STATE, 2);
        want(base + 25, S_RDY, 0);
        want(base + 31, S_RDY, 0);
        want(base + 32, S_RDY, 1);
        want(base + 32, S_LOSS, 0);
        wait_until(base + 10);
        pll_locked = 1'b1;
        wait_until(base + 16);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        want(base + 42, S_RDY, 1);
        want(base + 42, S_LOSS, 0);
        want(base + 43, S_RDY, 0);
        want(base + 43, S_SRST, 1);
        want(base + 43, S_LOSS, 1);
        want(base + 43, S_STATE, LOSS_STATE);
        want(base + 64, S_RDY, 0);
        want(base + 65, S_RDY, 1);
        want(base + 65, S_LOSS, 1);
        wait_until(base + 40);
        pll_locked = 1'b0;
        wait_until(base + 50);
        pll_locked = 1'b1;
        wait_until(base + 70);

        // Never lock
        pll_locked = 1'b0;
        do_reset(base);
        want(base + 2, S_PRST, 1);
        want(base + 3, S_PRST, 0);
`ifdef PLL_AUTO_RESET_EN
        want(base + 52,  S_PRST, 0);
        want(base + 52,  S_TMO, 0);
        want(base + 53,  S_PRST, 1);
        want(base + 53,  S_TMO, 1);
        want(base + 55,  S_PRST, 1);
        want(base + 56,  S_PRST, 0);
        want(base + 105, S_PRST, 0);
        want(base + 106, S_PRST, 1);
        want(base + 106, S_TMO, 2);
        want(base + 200, S_TMO, 3);
`else
        want(base + 52,  S_PRST, 0);
        want(base + 53,  S_PRST, 0);
        want(base + 53,  S_TMO, 0);
        want(base + 106, S_PRST, 0);
        want(base + 106, S_STATE, 1);
        want(base + 200, S_STATE, 1);
        want(base + 200, S_TMO, 0);
`endif
        wait_until(base + 205);

        // Saturation of the loss counter
        pll_locked = 1'b1;
        do_reset(base);
        want(base + 16, S_RDY, 1);
        k = base + 20;
        for (int i = 0; i < 260; i++) begin
            wait_until(k);
            pll_locked = 1'b0;
            want(k + 3, S_LOSS, (i + 1 > 255) ? 255 : i + 1);
            want(k + RELOCK, S_RDY, 1);
            tick();
            pll_locked = 1'b1;
            k = k + RELOCK + 4;
        end

        // Clear coincident with a loss
        wait_until(k);
        pll_locked = 1'b0;
        want(k + 2, S_LOSS, 255);
        want(k + 3, S_LOSS, 0);
        want(k + 3, S_RDY, 0);
        want(k + 4, S_LOSS, 0);
        want(k + 4, S_TMO, 0);
        tick();
        pll_locked = 1'b1;
        wait_until(k + 2);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        k = k + RELOCK + 4;

        // Reset while in RUN
        wait_until(k);
        pll_locked = 1'b0;
        want(k + 3, S_LOSS, 1);
        tick();
        pll_locked = 1'b1;
        r = k + RELOCK + 3;
        want(r, S_RDY, 1);
        want(r, S_LOSS, 1);
        want(r + 1, S_PRST, 1);
        want(r + 1, S_SRST, 1);
        want(r + 1, S_RDY, 0);
        want(r + 1, S_LOSS, 0);
        want(r + 1, S_TMO, 0);
        want(r + 1, S_STATE, 0);
        want(r + 3, S_PRST, 1);
        want(r + 4, S_PRST, 0);
        wait_until(r);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_until(r + 8);

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            n_vec += sb.size();
            n_bad += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Consumes the PLL `locked` status and drives the PLL reset input.
- Qualifies lock as stable, then releases a system reset to downstream logic in the PLL output domain.
- Runs on the 125 MHz reference clock, which is valid before lock.
- Counts lock-loss and lock-timeout events for status readback.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on pll_locked; legal range 2..4.
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per PLL reset pulse; must be ≥1.
- LOCK_STABLE_CYCLES, 1250: consecutive synchronized-locked cycles required (10 us at 125 MHz); must be ≥1.
- RELEASE_DELAY, 125: cycles sys_rst is still held after stable lock; must be ≥1.
- LOCK_TIMEOUT, 125000: maximum cycles in WAIT_LOCK before the PLL is re-reset; must be ≥1.
- CNT_W, 8: width of the event counters.

Ports:
- refclk  in  1  reference clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked; asynchronous to refclk.
- cnt_clr  in  1  single-cycle pulse; clears both event counters.
- pll_rst  out  1  reset to the PLL.
- sys_rst  out  1  downstream system reset, active-high; level output, re-synchronized by consumers.
- ready  out  1  high only in RUN.
- lock_loss_count  out  CNT_W  saturating count of lock losses seen in RUN.
- timeout_count  out  CNT_W  saturating count of WAIT_LOCK timeouts.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Clocking and reset: one clock, refclk. Reset is synchronous and active-high on rst.
- While rst=1, the next edge sets:
  - pll_rst=1, sys_rst=1, ready=0
  - counters=0, synchronizer flops=0
  - state=PLL_RST, cycle counter=0
- rst asserted mid-operation aborts any state at the next edge. No partial outputs.
- Synchronizer: pll_locked passes through SYNC_STAGES flops to give locked_s.
- All outputs are registered, decoded from the state register.
- FSM:
  - PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0, sys_rst=1.
    - locked_s=1: go to STABLE, counter cleared.
    - Counter reaches LOCK_TIMEOUT-1 with locked_s=0: timeout event (see Optional Feature).
  - STABLE: counter increments while locked_s=1.
    - locked_s=0: go to WAIT_LOCK with counter cleared. Not counted as a loss.
    - After LOCK_STABLE_CYCLES cycles: go to RELEASE.
  - RELEASE: sys_rst=1 for RELEASE_DELAY cycles, then go to RUN.
    - locked_s=0: go to WAIT_LOCK. Not counted.
  - RUN: sys_rst=0, ready=1.
    - locked_s=0: next edge sets sys_rst=1, ready=0, lock_loss_count+1, state=WAIT_LOCK (or PLL_RST with the macro).
- Latency: let T0 be the first WAIT_LOCK cycle with locked_s=1. Then ready=1 and sys_rst=0 at cycle T0+1+LOCK_STABLE_CYCLES+RELEASE_DELAY.
- Counters:
  - Saturate at 2^CNT_W-1.
  - cnt_clr wins over a simultaneous increment; both counters read 0 on the next cycle.
- Width: the internal cycle counter width is $clog2 of the largest cycle parameter, plus 1.

Optional Feature:
- Macro: PLL_AUTO_RESET_EN.
- Defined:
  - WAIT_LOCK timeout → timeout_count+1, go to PLL_RST (re-pulse the PLL).
  - RUN lock loss → PLL_RST.
- Undefined:
  - pll_rst is pulsed only once after rst.
  - WAIT_LOCK waits indefinitely; the counter holds at its maximum, no timeout event.
  - timeout_count is tied to 0.
  - RUN lock loss → WAIT_LOCK.

Decomposition:
- Package pll_lock_seq_pkg:
  - state enum typedef: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4
  - default parameter constants
- Sub-module bit_sync (parameter STAGES): multi-flop synchronizer with synchronous reset. Everything else stays in one module.

Test Plan (SYNC_STAGES=2, PLL_RST_CYCLES=3, LOCK_STABLE_CYCLES=8, RELEASE_DELAY=4, LOCK_TIMEOUT=50, CNT_W=8):
1. Clean lock: rst released at cycle 0; pll_locked rises at cycle 10 and holds → pll_rst high for cycles 0-2; locked_s high at cycle 12; ready=1, sys_rst=0 from cycle 25.
2. Glitch in STABLE: pll_locked low for 1 cycle after 5 stable cycles → returns to WAIT_LOCK, lock_loss_count stays 0; ready delayed by the restart, then still asserts.
3. Loss in RUN: drop pll_locked → ready=0 and sys_rst=1 exactly 3 edges later (2 sync + 1 register); lock_loss_count goes 0→1.
4. Never lock, macro defined: pll_rst re-pulses for 3 cycles every 53 cycles and timeout_count increments each time. Macro undefined: pll_rst stays 0, timeout_count stays 0, state stays WAIT_LOCK.
5. Saturation and clear: 260 loss events → lock_loss_count=255. Then cnt_clr on the same cycle as a loss → count=0.
6. rst=1 while in RUN → next edge: pll_rst=1, sys_rst=1, ready=0, counts=0, state_dbg=0.
